fetch_unit: RTL and testbench

Instruction fetch stage with in-order prefetch buffering, placed directly upstream of the single-cycle core's decode. It owns the fetch PC, issues word reads to instruction memory over a valid/ready request and in-order response interface, and buffers returned instructions with their PCs. It hands them to decode over a valid/ready interface. Control-flow redirects from the execute stage flush the buffer and discard in-flight responses.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, PC increment and buffer entry type for the fetch stage.
package fetch_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched instruction/PC pairs; flush overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  always_comb begin
    do_push = push && !flush;
    do_pop  = pop && !flush && (count != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with credit-limited prefetch into an in-order buffer;
// redirects flush the buffer and drop responses still in flight.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] target_pc;
  logic            req_fire;
  logic            pop;
  logic            push;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  always_comb begin
    mem_req_valid   = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_W;
    mem_req_addr    = fetch_pc;
    req_fire        = mem_req_valid && mem_req_ready;
    inst_valid      = count != '0;
    inst_data       = head.inst;
    inst_pc         = head.pc;
    pop             = inst_valid && inst_ready;
    outstanding_nxt = outstanding + CW'(req_fire) - CW'(mem_rsp_valid);
    target_pc       = redirect_pc & ~32'd3;
    // A response landing in a redirect cycle belongs to the old stream.
    push            = mem_rsp_valid && (discard == '0) && !redirect_valid;
    push_entry.inst = mem_rsp_data;
    push_entry.pc   = rsp_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        discard  <= outstanding_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (mem_rsp_valid) begin
          if (discard != '0) discard <= discard - CW'(1);
          else               rsp_pc  <= rsp_pc + PC_STEP;
        end
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with variable
// latency plus a PC scoreboard filled on request acceptance.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(4)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  typedef struct {
    logic        irdy;
    logic        exp_rv;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  pend_t       pend[$];
  logic [31:0] sb[$];
  logic [31:0] exp_fetch;
  int unsigned edge_n   = 0;
  int unsigned last_due = 0;
  int unsigned lat      = 1;
  int unsigned checks   = 0;
  int unsigned errors   = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: account handshakes seen before the edge, then present the next response.
  task automatic cycle();
    logic        fire;
    logic        popd;
    logic [31:0] e_pc;
    pend_t       p;
    fire = mem_req_valid && mem_req_ready;
    popd = inst_valid && inst_ready;
    if (!rst_n) begin
      pend.delete();
      sb.delete();
      exp_fetch = RESET_PC;
    end else begin
      if (mem_rsp_valid) begin
        assert (pend.size() != 0)
          else $error("FAIL rsp_without_request: response with nothing outstanding");
        if (pend.size() != 0) void'(pend.pop_front());
      end
      if (fire) begin
        chk("req_addr", mem_req_addr, exp_fetch);
        p.addr = mem_req_addr;
        p.due  = edge_n + lat;
        if (p.due <= last_due) p.due = last_due + 1;
        last_due = p.due;
        pend.push_back(p);
      end
      if (redirect_valid) begin
        sb.delete();
        exp_fetch = redirect_pc & ~32'd3;
      end else begin
        if (fire) begin
          sb.push_back(exp_fetch);
          exp_fetch = exp_fetch + 32'd4;
        end
        if (popd) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got pc %h expected no instruction", inst_pc);
          end else begin
            e_pc = sb.pop_front();
            chk("pop_pc", inst_pc, e_pc);
            chk("pop_data", inst_data, inst_of(e_pc));
          end
        end
      end
    end
    @(posedge clk);
    #1;
    edge_n++;
    if (pend.size() != 0 && pend[0].due <= edge_n) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = inst_of(pend[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic wait_pop(input string name, input logic [31:0] exp_pc, input int unsigned max_cyc);
    bit seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < max_cyc && !seen; i++) begin
      if (inst_valid && inst_ready) begin
        chk(name, inst_pc, exp_pc);
        seen = 1'b1;
      end
      cycle();
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no instruction within %0d cycles, required pc %h", name, max_cyc, exp_pc);
    end
  endtask

  vec_t tbl[19];

  initial begin
    // Post-reset stream at latency 1, then a 10-cycle decode stall and release.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h4};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h8};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'hC};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'hC};
    for (int i = 6; i < 15; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 32'hC};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 32'h10};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 32'h14};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 32'h18};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 32'h1C};

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    inst_ready     = 1'b1;
    exp_fetch      = RESET_PC;
    run(2);
    chk("reset_req_valid", 32'(mem_req_valid), 32'd1);
    chk("reset_req_addr", mem_req_addr, RESET_PC);
    chk("reset_inst_valid", 32'(inst_valid), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      inst_ready = tbl[i].irdy;
      cycle();
      chk($sformatf("tbl%0d_req_valid", i), 32'(mem_req_valid), 32'(tbl[i].exp_rv));
      chk($sformatf("tbl%0d_inst_valid", i), 32'(inst_valid), 32'(tbl[i].exp_iv));
      if (tbl[i].exp_iv) chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].exp_pc);
    end

    // Redirect coinciding with a request acceptance and a response.
    run(4);
    chk("same_cycle_setup", {30'd0, mem_req_valid & mem_req_ready, mem_rsp_valid}, 32'd3);
    redirect_to(32'h0000_0180);
    chk("same_cycle_discard", 32'(u_dut.discard), pend.size());
    chk("same_cycle_inst_valid", 32'(inst_valid), 32'd0);
    wait_pop("same_cycle_first_pc", 32'h0000_0180, 12);
    run(6);

    // Redirect with several requests in flight at latency 3.
    lat = 3;
    run(8);
    redirect_to(32'h0000_0100);
    chk("redir_inst_valid", 32'(inst_valid), 32'd0);
    chk("redir_req_addr", mem_req_addr, 32'h0000_0100);
    chk("redir_discard", 32'(u_dut.discard), pend.size());
    wait_pop("redir_first_pc", 32'h0000_0100, 20);
    run(8);

    // Back-to-back redirects; only the second target stream may appear.
    redirect_to(32'h0000_0200);
    redirect_to(32'h0000_0300);
    chk("b2b_inst_valid", 32'(inst_valid), 32'd0);
    chk("b2b_req_addr", mem_req_addr, 32'h0000_0300);
    wait_pop("b2b_first_pc", 32'h0000_0300, 20);
    run(12);

    // Unaligned target and PC wrap through 2^32.
    lat = 1;
    run(6);
    redirect_to(32'hFFFF_FFFA);
    chk("wrap_req_addr", mem_req_addr, 32'hFFFF_FFF8);
    wait_pop("wrap_first_pc", 32'hFFFF_FFF8, 12);
    run(8);

    // Fill the buffer, then reset mid-stream.
    inst_ready = 1'b0;
    run(10);
    chk("full_req_valid", 32'(mem_req_valid), 32'd0);
    chk("full_inst_valid", 32'(inst_valid), 32'd1);
    rst_n = 1'b0;
    cycle();
    chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_req_addr", mem_req_addr, RESET_PC);
    chk("midrst_req_valid", 32'(mem_req_valid), 32'd1);
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    wait_pop("midrst_first_pc", RESET_PC, 10);
    run(6);

    // Random backpressure, latency and redirects.
    for (int unsigned i = 0; i < 400; i++) begin
      inst_ready    = ($urandom_range(3) != 0);
      mem_req_ready = ($urandom_range(2) != 0);
      if ($urandom_range(15) == 0) lat = 1 + $urandom_range(3);
      if ($urandom_range(24) == 0) redirect_to($urandom & 32'h0000_FFFF);
      else cycle();
    end
    inst_ready    = 1'b1;
    mem_req_ready = 1'b1;
    run(30);
    chk("drain_inst_valid_matches_model", 32'(inst_valid), 32'(sb.size() != 0 && pend.size() < sb.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
